perf_counter_unit: RTL and testbench

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

---
 rtl/perf_pkg.sv | 16 +
 rtl/perf_ctr_cell.sv | 49 ++++
 rtl/perf_counter_unit.sv | 113 +++++++++++
 tb/tb_perf_counter_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter unit: FSM state encoding
// and the read-select width helper.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_HALTED  = 2'd2
    } perf_state_e;

    // Width of a select that addresses the cycle counter plus n_ev event counters.
    function automatic int sel_width(input int n_ev);
        return (n_ev < 1) ? 1 : $clog2(n_ev + 1);
    endfunction

endpackage

// File: rtl/perf_ctr_cell.sv
// One performance counter: increment, synchronous clear, wrap or saturate
// at all-ones, and a sticky overflow flag.
module perf_ctr_cell #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
        at_max = &cnt_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            ovf_d = ovf_q | at_max;
            if (!(SATURATE && at_max)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance counter unit: a run/stop/halt FSM gating one cycle counter and
// N_EV event counters, with snapshot shadow registers and a registered read port.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int N_EV     = 3,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0,
    localparam int SEL_W   = sel_width(N_EV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             instr_valid,
    input  logic [N_EV-1:0]  event_in,
    input  logic [CNT_W-1:0] limit,
    input  logic             snap,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [1:0]       state_o,
    output logic             limit_hit,
    output logic [N_EV:0]    ovf
);

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_EV);

    perf_state_e                 state_q, state_d;
    logic                        count_en;
    logic                        halt;
    logic [CNT_W-1:0]            cyc_next;
    logic [N_EV:0]               inc;
    logic [N_EV:0]               ovf_w;
    logic [N_EV:0][CNT_W-1:0]    live;
    logic [N_EV:0][CNT_W-1:0]    shadow_q;
    logic [CNT_W-1:0]            rd_data_q, rd_data_d;
    logic                        limit_hit_q;

    // Clear suppresses this cycle's increments, which also rules out a limit halt.
    always_comb begin
        count_en = (state_q == ST_RUNNING) && instr_valid && !clear;
        cyc_next = (SATURATE && (&live[0])) ? live[0] : live[0] + CNT_W'(1);
        halt     = count_en && (limit != '0) && (cyc_next == limit);
        inc      = '0;
        inc[0]   = count_en;
        for (int i = 0; i < N_EV; i++) begin
            inc[i+1] = count_en & event_in[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: if (!clear && start && !stop) state_d = ST_RUNNING;
            ST_RUNNING: begin
                if (clear)     state_d = ST_RUNNING;
                else if (halt) state_d = ST_HALTED;
                else if (stop) state_d = ST_STOPPED;
            end
            ST_HALTED:  if (clear) state_d = ST_STOPPED;
            default:    state_d = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STOPPED;
            limit_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_hit_q <= halt;
        end
    end

    for (genvar i = 0; i <= N_EV; i++) begin : g_ctr
        perf_ctr_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_ctr (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .inc   (inc[i]),
            .cnt_o (live[i]),
            .ovf_o (ovf_w[i])
        );
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_sel <= MAX_SEL) begin
            rd_data_d = shadow_q[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the shadow array is reset explicitly because software may read it before the first snapshot.
        if (rst) begin
            shadow_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (snap) shadow_q <= live;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign state_o   = state_q;
    assign limit_hit = limit_hit_q;
    assign ovf       = ovf_w;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit: a default-width instance
// plus two 4-bit instances (wrapping and saturating) sharing the same stimulus.
module tb_perf_counter_unit;

    logic        clk;
    logic        rst, start, stop, clear, instr_valid, snap;
    logic [2:0]  event_in;
    logic [31:0] limit;
    logic [3:0]  limit4;
    logic [1:0]  rd_sel;

    logic [31:0] rd_data;
    logic [1:0]  state_o;
    logic        limit_hit;
    logic [3:0]  ovf;

    logic [3:0]  w_rd_data, s_rd_data;
    logic [1:0]  w_state, s_state;
    logic        w_hit, s_hit;
    logic [3:0]  w_ovf, s_ovf;

    int errors = 0;
    int checks = 0;

    perf_counter_unit dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .instr_valid(instr_valid), .event_in(event_in), .limit(limit),
        .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data), .state_o(state_o),
        .limit_hit(limit_hit), .ovf(ovf)
    );

    perf_counter_unit #(.N_EV(3), .CNT_W(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .instr_valid(instr_valid), .event_in(event_in), .limit(limit4),
        .snap(snap), .rd_sel(rd_sel), .rd_data(w_rd_data), .state_o(w_state),
        .limit_hit(w_hit), .ovf(w_ovf)
    );

    perf_counter_unit #(.N_EV(3), .CNT_W(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .instr_valid(instr_valid), .event_in(event_in), .limit(limit4),
        .snap(snap), .rd_sel(rd_sel), .rd_data(s_rd_data), .state_o(s_state),
        .limit_hit(s_hit), .ovf(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        rd_sel = sel;
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        instr_valid = 1'b0; snap = 1'b0; event_in = 3'b000;
        limit = 32'd0; limit4 = 4'd0; rd_sel = 2'd0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_state", state_o, 2'd0);
        check("rst_ovf", ovf, 4'd0);
        check("rst_hit", limit_hit, 1'b0);
        check("rst_rd", rd_data, 32'd0);
        check("rst_w_state", w_state, 2'd0);

        // Basic counting: 10 cycles, event 0 on 4 of them
        start = 1'b1; tick(); start = 1'b0;
        check("run_state", state_o, 2'd1);
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            event_in = (i < 4) ? 3'b001 : 3'b000;
            tick();
        end
        instr_valid = 1'b0; event_in = 3'b000;
        do_snap();
        read_chk("cyc10", 2'd0, 32'd10);
        read_chk("ev0_4", 2'd1, 32'd4);
        read_chk("ev1_0", 2'd2, 32'd0);

        // Events ignored while instr_valid is low
        event_in = 3'b111;
        repeat (6) tick();
        event_in = 3'b000;
        do_snap();
        read_chk("idle_cyc", 2'd0, 32'd10);
        read_chk("idle_ev0", 2'd1, 32'd4);
        read_chk("idle_ev2", 2'd3, 32'd0);

        // start and stop together from RUNNING
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("startstop", state_o, 2'd0);

        // clear coinciding with an increment
        start = 1'b1; tick(); start = 1'b0;
        instr_valid = 1'b1; event_in = 3'b111; clear = 1'b1;
        tick();
        instr_valid = 1'b0; event_in = 3'b000; clear = 1'b0;
        check("clr_state", state_o, 2'd1);
        read_chk("shadow_kept", 2'd0, 32'd10);
        do_snap();
        read_chk("clr_cyc", 2'd0, 32'd0);
        read_chk("clr_ev1", 2'd2, 32'd0);

        // Snapshot captures pre-update values
        instr_valid = 1'b1; event_in = 3'b010; tick();
        snap = 1'b1; tick(); snap = 1'b0;
        instr_valid = 1'b0; event_in = 3'b000;
        read_chk("snap_pre_cyc", 2'd0, 32'd1);
        read_chk("snap_pre_ev1", 2'd2, 32'd1);
        do_snap();
        read_chk("snap_post_cyc", 2'd0, 32'd2);

        // 4-bit wrap vs saturate after 17 counts
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        instr_valid = 1'b1;
        repeat (17) tick();
        instr_valid = 1'b0;
        check("wrap_ovf", w_ovf, 4'b0001);
        check("sat_ovf", s_ovf, 4'b0001);
        check("big_ovf", ovf, 4'b0000);
        do_snap();
        rd_sel = 2'd0; tick();
        check("wrap_cnt", w_rd_data, 4'd1);
        check("sat_cnt", s_rd_data, 4'd15);
        check("big_cnt", rd_data, 32'd17);

        // Limit auto-halt at 5
        rst = 1'b1; tick(); rst = 1'b0;
        limit = 32'd5;
        start = 1'b1; tick(); start = 1'b0;
        instr_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("lim_hit_%0d", i), limit_hit, (i == 5) ? 1'b1 : 1'b0);
            check($sformatf("lim_state_%0d", i), state_o, (i >= 5) ? 2'd2 : 2'd1);
        end
        start = 1'b1; tick(); start = 1'b0;
        instr_valid = 1'b0;
        check("halt_ign_start", state_o, 2'd2);
        do_snap();
        read_chk("halt_cyc", 2'd0, 32'd5);
        clear = 1'b1; tick(); clear = 1'b0;
        check("halt_clear", state_o, 2'd0);
        limit = 32'd0;

        // rst mid-run after 7 counts
        start = 1'b1; tick(); start = 1'b0;
        instr_valid = 1'b1; event_in = 3'b111;
        repeat (7) tick();
        snap = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; snap = 1'b0; instr_valid = 1'b0; event_in = 3'b000;
        check("mrst_state", state_o, 2'd0);
        check("mrst_ovf", ovf, 4'd0);
        check("mrst_w_ovf", w_ovf, 4'd0);
        check("mrst_rd", rd_data, 32'd0);
        do_snap();
        for (int s = 0; s < 4; s++) begin
            read_chk($sformatf("mrst_rd%0d", s), 2'(s), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
